operand_fetch: RTL and testbench

- Pipeline stage directly upstream of the register file.
- Accepts decoded instructions with a valid/ready handshake and drives the register file's two read addresses.
- Absorbs the register file's one-cycle synchronous read latency, and forwards the previous cycle's write so operands are never stale.
- Also owns the register file write port: gates writeback requests into the write mask. Delivers operand pairs downstream with a valid/ready handshake.

---
 rtl/operand_fetch.sv | 193 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: pipeline stage in front of a synchronous-read register file.
// S1 holds an accepted instruction while its register read is in flight.
// S2 is the output register. The previous cycle's writeback is merged into
// the read data so that operands are never stale. This module also gates
// writeback requests onto the register file write port.
module operand_fetch #(
    parameter int N   = 32,  // operand / register width
    parameter int M   = 2,   // register id width
    parameter int OPW = 4    // opaque opcode width
) (
    input  logic           clk,
    input  logic           rst_n,
    // upstream instruction handshake
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   in_r1,
    input  logic [M-1:0]   in_r2,
    input  logic [M-1:0]   in_dest,
    input  logic [OPW-1:0] in_op,
    // writeback request
    input  logic           wb_valid,
    input  logic [M-1:0]   wb_id,
    input  logic [N-1:0]   wb_mask,
    input  logic [N-1:0]   wb_data,
    // register file ports
    output logic [M-1:0]   rf_r1,
    output logic [M-1:0]   rf_r2,
    output logic [M-1:0]   rf_w1,
    output logic [N-1:0]   rf_mask,
    output logic [N-1:0]   rf_w,
    input  logic [N-1:0]   rf_v1,
    input  logic [N-1:0]   rf_v2,
    // downstream operand handshake
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_a,
    output logic [N-1:0]   out_b,
    output logic [M-1:0]   out_dest,
    output logic [OPW-1:0] out_op
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic           s1_valid_reg;
    logic [M-1:0]   s1_r1_reg;
    logic [M-1:0]   s1_r2_reg;
    logic [M-1:0]   s1_dest_reg;
    logic [OPW-1:0] s1_op_reg;

    logic           wbq_valid_reg;
    logic [M-1:0]   wbq_id_reg;
    logic [N-1:0]   wbq_mask_reg;
    logic [N-1:0]   wbq_data_reg;

    logic           out_valid_reg;
    logic [N-1:0]   out_a_reg;
    logic [N-1:0]   out_b_reg;
    logic [M-1:0]   out_dest_reg;
    logic [OPW-1:0] out_op_reg;

    // ------------------------------------------------------------------
    // Handshake terms
    // ------------------------------------------------------------------
    logic s2_free;
    logic s1_adv;
    logic s1_stall;
    logic accept;

    // Occupancy/flow terms for both stages; S1 may refill in the cycle it drains.
    always_comb begin
        s2_free  = !out_valid_reg || out_ready;
        s1_adv   = s1_valid_reg && s2_free;
        s1_stall = s1_valid_reg && !s1_adv;
        in_ready = !s1_valid_reg || s1_adv;
        accept   = in_valid && in_ready;
    end

    // ------------------------------------------------------------------
    // Register file read addresses
    // ------------------------------------------------------------------
    // A stalled S1 keeps re-reading its own registers so that the read data
    // presented when it finally advances includes every write up to then.
    always_comb begin
        rf_r1 = in_r1;
        rf_r2 = in_r2;
        if (s1_stall) begin
            rf_r1 = s1_r1_reg;
            rf_r2 = s1_r2_reg;
        end
    end

    // ------------------------------------------------------------------
    // Register file write port: a zero mask leaves the file unchanged
    // ------------------------------------------------------------------
    // Writeback is never stalled; only the mask is gated by wb_valid.
    always_comb begin
        rf_w1   = wb_id;
        rf_w    = wb_data;
        rf_mask = wb_valid ? wb_mask : '0;
    end

    // ------------------------------------------------------------------
    // Bypass of last cycle's write
    // ------------------------------------------------------------------
    // The read data arriving now was sampled before last cycle's write
    // landed, so that write is captured here and merged bit-wise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbq_valid_reg <= 1'b0;
            wbq_id_reg    <= '0;
            wbq_mask_reg  <= '0;
            wbq_data_reg  <= '0;
        end else begin
            wbq_valid_reg <= wb_valid;
            wbq_id_reg    <= wb_id;
            wbq_mask_reg  <= wb_mask;
            wbq_data_reg  <= wb_data;
        end
    end

    // One forwarding path per read port.
    logic [M-1:0] src_id [2];
    logic [N-1:0] rf_val [2];
    logic [N-1:0] fwd    [2];

    assign src_id[0] = s1_r1_reg;
    assign src_id[1] = s1_r2_reg;
    assign rf_val[0] = rf_v1;
    assign rf_val[1] = rf_v2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit;
            assign hit     = wbq_valid_reg && (wbq_id_reg == src_id[gi]);
            assign fwd[gi] = hit ? ((rf_val[gi] & ~wbq_mask_reg) |
                                    (wbq_data_reg & wbq_mask_reg))
                                 : rf_val[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // S1: instruction whose register read is in flight
    // ------------------------------------------------------------------
    // Load on accept; otherwise empty when the held instruction moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_r1_reg    <= '0;
            s1_r2_reg    <= '0;
            s1_dest_reg  <= '0;
            s1_op_reg    <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_r1_reg    <= in_r1;
            s1_r2_reg    <= in_r2;
            s1_dest_reg  <= in_dest;
            s1_op_reg    <= in_op;
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // S2: output register, frozen while downstream is not ready
    // ------------------------------------------------------------------
    // Capture forwarded operands on advance; drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_a_reg     <= '0;
            out_b_reg     <= '0;
            out_dest_reg  <= '0;
            out_op_reg    <= '0;
        end else if (s1_adv) begin
            out_valid_reg <= 1'b1;
            out_a_reg     <= fwd[0];
            out_b_reg     <= fwd[1];
            out_dest_reg  <= s1_dest_reg;
            out_op_reg    <= s1_op_reg;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_a     = out_a_reg;
    assign out_b     = out_b_reg;
    assign out_dest  = out_dest_reg;
    assign out_op    = out_op_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural register file surrounds the DUT and
// a queue-level reference model predicts handshakes and operand values from
// the architectural register contents at the time each instruction leaves S1.
module tb_operand_fetch;

    localparam int N   = 32;
    localparam int M   = 2;
    localparam int OPW = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [M-1:0]   in_r1;
    logic [M-1:0]   in_r2;
    logic [M-1:0]   in_dest;
    logic [OPW-1:0] in_op;
    logic           wb_valid;
    logic [M-1:0]   wb_id;
    logic [N-1:0]   wb_mask;
    logic [N-1:0]   wb_data;
    logic [M-1:0]   rf_r1;
    logic [M-1:0]   rf_r2;
    logic [M-1:0]   rf_w1;
    logic [N-1:0]   rf_mask;
    logic [N-1:0]   rf_w;
    logic [N-1:0]   rf_v1;
    logic [N-1:0]   rf_v2;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_a;
    logic [N-1:0]   out_b;
    logic [M-1:0]   out_dest;
    logic [OPW-1:0] out_op;

    operand_fetch #(.N(N), .M(M), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r1     (in_r1),
        .in_r2     (in_r2),
        .in_dest   (in_dest),
        .in_op     (in_op),
        .wb_valid  (wb_valid),
        .wb_id     (wb_id),
        .wb_mask   (wb_mask),
        .wb_data   (wb_data),
        .rf_r1     (rf_r1),
        .rf_r2     (rf_r2),
        .rf_w1     (rf_w1),
        .rf_mask   (rf_mask),
        .rf_w      (rf_w),
        .rf_v1     (rf_v1),
        .rf_v2     (rf_v2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_dest  (out_dest),
        .out_op    (out_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: register file with synchronous read (old data on a
    // same-edge write) and masked write. Not reset by rst_n.
    logic [N-1:0] rf_mem [4];
    initial begin
        for (int i = 0; i < 4; i++) rf_mem[i] = '0;
        rf_v1 = '0;
        rf_v2 = '0;
    end
    always @(posedge clk) begin
        rf_v1 <= rf_mem[rf_r1];
        rf_v2 <= rf_mem[rf_r2];
        rf_mem[rf_w1] <= (rf_mem[rf_w1] & ~rf_mask) | (rf_w & rf_mask);
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: architectural registers, a one-deep queue of
    // instructions awaiting operand capture, and the predicted output slot.
    // ------------------------------------------------------------------
    typedef struct {
        logic [M-1:0]   r1;
        logic [M-1:0]   r2;
        logic [M-1:0]   dest;
        logic [OPW-1:0] op;
    } inst_t;

    logic [N-1:0]   arch [4];
    inst_t          pend [$];
    bit             exp_full;
    logic [N-1:0]   exp_a;
    logic [N-1:0]   exp_b;
    logic [M-1:0]   exp_dest;
    logic [OPW-1:0] exp_op;
    int             n_out;

    initial begin
        for (int i = 0; i < 4; i++) arch[i] = '0;
        exp_full = 0;
        n_out    = 0;
    end

    // One clock cycle: compare registered outputs, drive new inputs, compare
    // combinational outputs, then advance the model to the coming edge.
    task automatic step(input bit iv, input int r1, input int r2, input int dest,
                        input int op, input bit wv, input int wid,
                        input logic [N-1:0] wm, input logic [N-1:0] wd, input bit ordy);
        bit    room;
        bit    move;
        bit    stall;
        inst_t p;
        @(negedge clk);
        in_valid  = iv;
        in_r1     = r1[M-1:0];
        in_r2     = r2[M-1:0];
        in_dest   = dest[M-1:0];
        in_op     = op[OPW-1:0];
        wb_valid  = wv;
        wb_id     = wid[M-1:0];
        wb_mask   = wm;
        wb_data   = wd;
        out_ready = ordy;
        #1;
        move  = (pend.size() > 0) && (!exp_full || ordy);
        room  = (pend.size() == 0) || move;
        stall = (pend.size() > 0) && !move;
        chk("out_valid", out_valid, exp_full);
        if (exp_full) begin
            chk("out_a", out_a, exp_a);
            chk("out_b", out_b, exp_b);
            chk("out_dest", out_dest, exp_dest);
            chk("out_op", out_op, exp_op);
            if (ordy) begin
                n_out++;
                $display("out #%0d: a=%08h b=%08h dest=%0d op=%0h", n_out, out_a, out_b, out_dest, out_op);
            end
        end
        chk("in_ready", in_ready, room);
        chk("rf_mask", rf_mask, wv ? wm : '0);
        chk("rf_w1", rf_w1, wid[M-1:0]);
        chk("rf_w", rf_w, wd);
        if (stall) begin
            chk("rf_r1", rf_r1, pend[0].r1);
            chk("rf_r2", rf_r2, pend[0].r2);
        end else begin
            chk("rf_r1", rf_r1, r1[M-1:0]);
            chk("rf_r2", rf_r2, r2[M-1:0]);
        end
        // model update for the coming edge
        if (move) begin
            p        = pend.pop_front();
            exp_a    = arch[p.r1];
            exp_b    = arch[p.r2];
            exp_dest = p.dest;
            exp_op   = p.op;
            exp_full = 1;
        end else if (exp_full && ordy) begin
            exp_full = 0;
        end
        if (iv && room) begin
            p.r1   = r1[M-1:0];
            p.r2   = r2[M-1:0];
            p.dest = dest[M-1:0];
            p.op   = op[OPW-1:0];
            pend.push_back(p);
        end
        if (wv) arch[wid] = (arch[wid] & ~wm) | (wd & wm);
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, 0, 0, '0, '0, ordy);
    endtask

    task automatic wr(input int id, input logic [N-1:0] d);
        step(0, 0, 0, 0, 0, 1, id, '1, d, 1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 0; in_r1 = '0; in_r2 = '0; in_dest = '0; in_op = '0;
        wb_valid  = 0; wb_id = '0; wb_mask = '0; wb_data = '0;
        out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_dest", out_dest, 0);
        chk("rst_out_op", out_op, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        repeat (4) idle(0);

        // back-to-back issue with preloaded registers
        wr(0, 32'h0); wr(1, 32'h11); wr(2, 32'h22); wr(3, 32'h33);
        idle(1);
        step(1, 1, 2, 1, 4'h1, 0, 0, '0, '0, 1);
        step(1, 3, 0, 2, 4'h2, 0, 0, '0, '0, 1);
        idle(1);
        chk("b2b_a0", out_a, 32'h11);
        chk("b2b_b0", out_b, 32'h22);
        idle(1);
        chk("b2b_a1", out_a, 32'h33);
        chk("b2b_b1", out_b, 32'h00);
        idle(1);

        // same-cycle forward, full mask
        step(1, 2, 2, 3, 4'h3, 1, 2, 32'hFFFFFFFF, 32'hAAAA5555, 1);
        idle(1);
        idle(1);
        chk("fwd_same_a", out_a, 32'hAAAA5555);
        chk("fwd_same_b", out_b, 32'hAAAA5555);
        idle(1);

        // partial-mask forward
        wr(1, 32'h12345678);
        step(1, 1, 0, 0, 4'h4, 1, 1, 32'h0000FF00, 32'hFFFFFFFF, 1);
        idle(1);
        idle(1);
        chk("fwd_part_a", out_a, 32'h1234FF78);
        idle(1);

        // stall with writes reaching the held instruction
        step(1, 1, 2, 1, 4'h5, 0, 0, '0, '0, 0);
        step(1, 3, 3, 2, 4'h6, 0, 0, '0, '0, 0);
        step(0, 0, 0, 0, 0, 1, 3, 32'hFFFFFFFF, 32'hDEADBEEF, 0);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_frozen_a", out_a, 32'h1234FF78);
        step(0, 0, 0, 0, 0, 1, 3, 32'h000000FF, 32'h00000011, 0);
        chk("stall_frozen_b", out_b, 32'hAAAA5555);
        idle(1);
        chk("stall_first_op", out_op, 4'h5);
        idle(1);
        chk("stall_second_a", out_a, 32'hDEADBE11);
        chk("stall_second_b", out_b, 32'hDEADBE11);
        idle(1);

        // asynchronous reset with both stages full
        step(1, 0, 1, 0, 4'h7, 0, 0, '0, '0, 0);
        step(1, 2, 3, 1, 4'h8, 0, 0, '0, '0, 0);
        @(negedge clk);
        in_valid = 0; wb_valid = 0; out_ready = 1;
        #1;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        pend.delete();
        exp_full = 0;
        @(posedge clk);
        #1;
        chk("async_rst_hold", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle(1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] m;
            int           sel;
            sel = $urandom_range(0, 2);
            m   = (sel == 0) ? '1 : (sel == 1) ? N'($urandom) : '0;
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 1), $urandom_range(0, 3), m, N'($urandom),
                 ($urandom_range(0, 9) < 7));
        end
        repeat (4) idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
